// File: rtl/varredor_teclado_pkg.sv
// Shared definitions for the keypad scanner: key codes, FSM states and the
// (row, column) to key-code lookup.
package pacote_teclado;

  localparam logic [3:0] TECLA_A    = 4'hA;
  localparam logic [3:0] TECLA_B    = 4'hB;
  localparam logic [3:0] TECLA_C    = 4'hC;
  localparam logic [3:0] TECLA_D    = 4'hD;
  localparam logic [3:0] TECLA_AST  = 4'hE;
  localparam logic [3:0] TECLA_CERQ = 4'hF;

  typedef enum logic [1:0] {
    VARRE,
    DEBOUNCE,
    EMITE,
    ESPERA_SOLTA
  } estado_teclado_t;

  // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic logic [3:0] codigo_tecla(input logic [1:0] linha,
                                              input logic [1:0] coluna);
    logic [3:0] codigo;
    case ({linha, coluna})
      4'h0:    codigo = 4'h1;
      4'h1:    codigo = 4'h2;
      4'h2:    codigo = 4'h3;
      4'h3:    codigo = TECLA_A;
      4'h4:    codigo = 4'h4;
      4'h5:    codigo = 4'h5;
      4'h6:    codigo = 4'h6;
      4'h7:    codigo = TECLA_B;
      4'h8:    codigo = 4'h7;
      4'h9:    codigo = 4'h8;
      4'hA:    codigo = 4'h9;
      4'hB:    codigo = TECLA_C;
      4'hC:    codigo = TECLA_AST;
      4'hD:    codigo = 4'h0;
      4'hE:    codigo = TECLA_CERQ;
      default: codigo = TECLA_D;
    endcase
    return codigo;
  endfunction

  function automatic logic [1:0] linha_mais_baixa(input logic [3:0] linhas);
    logic [1:0] idx;
    if (!linhas[0])      idx = 2'd0;
    else if (!linhas[1]) idx = 2'd1;
    else if (!linhas[2]) idx = 2'd2;
    else                 idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/varredor_teclado_sincronizador.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
module sincronizador #(
  parameter int unsigned         LARGURA     = 4,
  parameter logic [LARGURA-1:0]  VALOR_RESET = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= VALOR_RESET;
      q    <= VALOR_RESET;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/varredor_teclado.sv
// 4x4 keypad scanner with debounce and valid/ready key-code output.
// Optional auto-repeat while a key is held: define TECLADO_REPETE_EN.
module varredor_teclado
  import pacote_teclado::*;
#(
  parameter int unsigned DIV_VARRE  = 1000,
  parameter int unsigned CICLOS_DEB = 20000,
  parameter int unsigned CICLOS_REP = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] linhas,
  output logic [3:0] colunas,
  output logic [3:0] dado,
  output logic       dado_valido,
  input  logic       pronto
);

  localparam int unsigned W_DIV = $clog2(DIV_VARRE);
  localparam int unsigned W_DEB = $clog2(CICLOS_DEB + 1);
  localparam logic [W_DIV-1:0] DIV_ULT = W_DIV'(DIV_VARRE - 1);
  localparam logic [W_DEB-1:0] DEB_ULT = W_DEB'(CICLOS_DEB - 1);

  if (DIV_VARRE < 2 || CICLOS_DEB < 1 || CICLOS_REP < 1) begin : g_param_invalido
    $error("varredor_teclado: DIV_VARRE >= 2, CICLOS_DEB >= 1, CICLOS_REP >= 1");
  end

  estado_teclado_t  estado, estado_n;
  logic [3:0]       linhas_s;
  logic [1:0]       col_idx, col_n;
  logic [W_DIV-1:0] div_cnt, div_n;
  logic [W_DEB-1:0] deb_cnt, deb_n;
  logic [3:0]       lin_lat, lin_lat_n;
  logic [1:0]       lin_idx, lin_idx_n;
  logic [3:0]       dado_n;
  logic             valido_n;

`ifdef TECLADO_REPETE_EN
  localparam int unsigned W_REP = $clog2(CICLOS_REP + 1);
  localparam logic [W_REP-1:0] REP_ULT = W_REP'(CICLOS_REP - 1);
  logic [W_REP-1:0] rep_cnt, rep_n;
`endif

  sincronizador #(
    .LARGURA     (4),
    .VALOR_RESET (4'hF)
  ) u_sinc_linhas (
    .clk (clk),
    .rst (rst),
    .d   (linhas),
    .q   (linhas_s)
  );

  assign colunas = ~(4'b0001 << col_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= VARRE;
      col_idx     <= '0;
      div_cnt     <= '0;
      deb_cnt     <= '0;
      lin_lat     <= '1;
      lin_idx     <= '0;
      dado        <= '0;
      dado_valido <= 1'b0;
    end else begin
      estado      <= estado_n;
      col_idx     <= col_n;
      div_cnt     <= div_n;
      deb_cnt     <= deb_n;
      lin_lat     <= lin_lat_n;
      lin_idx     <= lin_idx_n;
      dado        <= dado_n;
      dado_valido <= valido_n;
    end
  end

`ifdef TECLADO_REPETE_EN
  always_ff @(posedge clk) begin
    if (rst) rep_cnt <= '0;
    else     rep_cnt <= rep_n;
  end
`endif

  always_comb begin
    estado_n  = estado;
    col_n     = col_idx;
    div_n     = div_cnt;
    deb_n     = deb_cnt;
    lin_lat_n = lin_lat;
    lin_idx_n = lin_idx;
    dado_n    = dado;
    valido_n  = dado_valido;
`ifdef TECLADO_REPETE_EN
    rep_n     = rep_cnt;
`endif

    case (estado)
      VARRE: begin
        // Sampling only at the end of the dwell lets the synchronizer settle
        // on the rows belonging to the column currently driven.
        if (div_cnt == DIV_ULT) begin
          div_n = '0;
          if (linhas_s != 4'hF) begin
            lin_lat_n = linhas_s;
            lin_idx_n = linha_mais_baixa(linhas_s);
            deb_n     = '0;
            estado_n  = DEBOUNCE;
          end else begin
            col_n = col_idx + 2'd1;
          end
        end else begin
          div_n = div_cnt + W_DIV'(1);
        end
      end

      DEBOUNCE: begin
        if (linhas_s == lin_lat) begin
          if (deb_cnt == DEB_ULT) begin
            deb_n    = '0;
            dado_n   = codigo_tecla(lin_idx, col_idx);
            valido_n = 1'b1;
            estado_n = EMITE;
          end else begin
            deb_n = deb_cnt + W_DEB'(1);
          end
        end else begin
          deb_n    = '0;
          div_n    = '0;
          col_n    = col_idx + 2'd1;
          estado_n = VARRE;
        end
      end

      EMITE: begin
        if (pronto) begin
          valido_n = 1'b0;
          deb_n    = '0;
`ifdef TECLADO_REPETE_EN
          rep_n    = '0;
`endif
          estado_n = ESPERA_SOLTA;
        end
      end

      ESPERA_SOLTA: begin
        if (linhas_s == 4'hF) begin
          if (deb_cnt == DEB_ULT) begin
            deb_n    = '0;
            div_n    = '0;
            col_n    = '0;
            estado_n = VARRE;
          end else begin
            deb_n = deb_cnt + W_DEB'(1);
          end
        end else begin
          deb_n = '0;
        end
`ifdef TECLADO_REPETE_EN
        // lin_lat always has a low bit, so this never overlaps the release path.
        if (linhas_s == lin_lat) begin
          if (rep_cnt == REP_ULT) begin
            rep_n    = '0;
            valido_n = 1'b1;
            estado_n = EMITE;
          end else begin
            rep_n = rep_cnt + W_REP'(1);
          end
        end else begin
          rep_n = '0;
        end
`endif
      end

      default: estado_n = VARRE;
    endcase
  end

endmodule
